// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA demosaicing gradient stage: pixel and
// gradient widths, the initiator state encoding and a saturating adder.
package cfa_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 16;

    localparam logic [GRAD_W-1:0] GRAD_MAX = {GRAD_W{1'b1}};

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } grad_init_state_t;

    // Unsigned add that clamps at GRAD_MAX instead of wrapping around
    function automatic logic [GRAD_W-1:0] sat_add(input logic [GRAD_W-1:0] a,
                                                  input logic [GRAD_W-1:0] b);
        logic [GRAD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[GRAD_W] ? GRAD_MAX : sum[GRAD_W-1:0];
    endfunction

endpackage

// File: rtl/abs_diff8.sv
// Combinational unsigned magnitude |a - b| of two pixel values.
module abs_diff8
    import cfa_pkg::*;
(
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    output logic [PIX_W-1:0] diff_o
);

    // Subtract the smaller operand from the larger so the result never wraps
    always_comb begin
        diff_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
    end

endmodule

// File: rtl/cfa_grad_init.sv
// Gradient-scaling initiator: sums |h_a-h_b| and |v_a-v_b| over PAIRS beats,
// launches the scaler with a start pulse, waits for its result and hands the
// scaled values downstream with a one-cycle valid strobe.
module cfa_grad_init
    import cfa_pkg::*;
#(
    parameter int PAIRS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  h_a,
    input  logic [PIX_W-1:0]  h_b,
    input  logic [PIX_W-1:0]  v_a,
    input  logic [PIX_W-1:0]  v_b,
    output logic [GRAD_W-1:0] grad_hs,
    output logic [GRAD_W-1:0] grad_vs,
    output logic              strat,
    input  logic [PIX_W-1:0]  scaled_hs,
    input  logic [PIX_W-1:0]  scaled_vs,
    input  logic              ready,
    output logic [PIX_W-1:0]  res_hs,
    output logic [PIX_W-1:0]  res_vs,
    output logic              res_valid
);

    localparam logic [7:0] CNT_LAST = 8'(PAIRS - 1);

    grad_init_state_t  state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [GRAD_W-1:0] acc_h_q, acc_h_d;
    logic [GRAD_W-1:0] acc_v_q, acc_v_d;
    logic [GRAD_W-1:0] grad_hs_q, grad_vs_q;
    logic [PIX_W-1:0]  res_hs_q, res_hs_d;
    logic [PIX_W-1:0]  res_vs_q, res_vs_d;
    logic [PIX_W-1:0]  diff_h, diff_v;

    abs_diff8 u_diff_h (
        .a_i    (h_a),
        .b_i    (h_b),
        .diff_o (diff_h)
    );

    abs_diff8 u_diff_v (
        .a_i    (v_a),
        .b_i    (v_b),
        .diff_o (diff_v)
    );

    // Next-state logic: accumulate beats, launch, wait for the scaler, clear
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_h_d  = acc_h_q;
        acc_v_d  = acc_v_q;
        res_hs_d = res_hs_q;
        res_vs_d = res_vs_q;
        case (state_q)
            ACCUM: begin
                if (pix_valid) begin
                    acc_h_d = sat_add(acc_h_q, {{(GRAD_W-PIX_W){1'b0}}, diff_h});
                    acc_v_d = sat_add(acc_v_q, {{(GRAD_W-PIX_W){1'b0}}, diff_v});
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ready) begin
                    res_hs_d = scaled_hs;
                    res_vs_d = scaled_vs;
                    state_d  = DONE;
                end
            end
            DONE: begin
                acc_h_d = '0;
                acc_v_d = '0;
                cnt_d   = '0;
                state_d = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State register; the gradient outputs track the next accumulator value
    // so they already carry the finished sums during the launch cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            acc_h_q   <= '0;
            acc_v_q   <= '0;
            grad_hs_q <= '0;
            grad_vs_q <= '0;
            res_hs_q  <= '0;
            res_vs_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_h_q   <= acc_h_d;
            acc_v_q   <= acc_v_d;
            grad_hs_q <= acc_h_d;
            grad_vs_q <= acc_v_d;
            res_hs_q  <= res_hs_d;
            res_vs_q  <= res_vs_d;
        end
    end

    // Handshake outputs are pure state decodes
    always_comb begin
        pix_ready = (state_q == ACCUM);
        strat     = (state_q == LAUNCH);
        res_valid = (state_q == DONE);
        grad_hs   = grad_hs_q;
        grad_vs   = grad_vs_q;
        res_hs    = res_hs_q;
        res_vs    = res_vs_q;
    end

endmodule

// File: tb/tb_cfa_grad_init.sv
// Directed bench for cfa_grad_init with three instances (PAIRS = 8, 255, 1)
// sharing one stimulus bus. Inputs change and outputs are observed on the
// falling clock edge.
module tb_cfa_grad_init;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid;
    logic [7:0] h_a, h_b, v_a, v_b;
    logic [7:0] scaled_hs, scaled_vs;
    logic       ready;

    logic        p8_pix_ready, p8_strat, p8_res_valid;
    logic [15:0] p8_grad_hs, p8_grad_vs;
    logic [7:0]  p8_res_hs, p8_res_vs;
    logic        pm_pix_ready, pm_strat, pm_res_valid;
    logic [15:0] pm_grad_hs, pm_grad_vs;
    logic [7:0]  pm_res_hs, pm_res_vs;
    logic        p1_pix_ready, p1_strat, p1_res_valid;
    logic [15:0] p1_grad_hs, p1_grad_vs;
    logic [7:0]  p1_res_hs, p1_res_vs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cfa_grad_init #(.PAIRS(8)) dut8 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(p8_pix_ready),
        .h_a(h_a), .h_b(h_b), .v_a(v_a), .v_b(v_b),
        .grad_hs(p8_grad_hs), .grad_vs(p8_grad_vs), .strat(p8_strat),
        .scaled_hs(scaled_hs), .scaled_vs(scaled_vs), .ready(ready),
        .res_hs(p8_res_hs), .res_vs(p8_res_vs), .res_valid(p8_res_valid)
    );

    cfa_grad_init #(.PAIRS(255)) dut255 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pm_pix_ready),
        .h_a(h_a), .h_b(h_b), .v_a(v_a), .v_b(v_b),
        .grad_hs(pm_grad_hs), .grad_vs(pm_grad_vs), .strat(pm_strat),
        .scaled_hs(scaled_hs), .scaled_vs(scaled_vs), .ready(ready),
        .res_hs(pm_res_hs), .res_vs(pm_res_vs), .res_valid(pm_res_valid)
    );

    cfa_grad_init #(.PAIRS(1)) dut1 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(p1_pix_ready),
        .h_a(h_a), .h_b(h_b), .v_a(v_a), .v_b(v_b),
        .grad_hs(p1_grad_hs), .grad_vs(p1_grad_vs), .strat(p1_strat),
        .scaled_hs(scaled_hs), .scaled_vs(scaled_vs), .ready(ready),
        .res_hs(p1_res_hs), .res_vs(p1_res_vs), .res_valid(p1_res_valid)
    );

    // Hold reset across two rising edges with all inputs idle, release at a falling edge
    task automatic apply_reset();
        pix_valid = 1'b0;
        ready     = 1'b0;
        h_a = 8'd0; h_b = 8'd0; v_a = 8'd0; v_b = 8'd0;
        scaled_hs = 8'd0; scaled_vs = 8'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer n consecutive beats with fixed pixels; returns at the falling edge after the last accept
    task automatic drive_beats(input int n, input logic [7:0] ha, input logic [7:0] hb,
                               input logic [7:0] va, input logic [7:0] vb);
        h_a = ha; h_b = hb; v_a = va; v_b = vb;
        pix_valid = 1'b1;
        repeat (n) @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (p8_pix_ready !== 1'b1 || p8_strat !== 1'b0 || p8_res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: ready/strat/valid = %b%b%b, required 100",
                     p8_pix_ready, p8_strat, p8_res_valid);
        end
        checks++;
        if (p8_grad_hs !== 16'd0 || p8_grad_vs !== 16'd0 || p8_res_hs !== 8'd0 || p8_res_vs !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: grad %0d/%0d res %0d/%0d, required all 0",
                     p8_grad_hs, p8_grad_vs, p8_res_hs, p8_res_vs);
        end
    endtask

    task automatic test_single_window();
        apply_reset();
        drive_beats(8, 8'd10, 8'd3, 8'd0, 8'd5);
        checks++;
        if (p8_strat !== 1'b1 || p8_pix_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_launch: strat=%b pix_ready=%b, required 1/0", p8_strat, p8_pix_ready);
        end
        checks++;
        if (p8_grad_hs !== 16'd56 || p8_grad_vs !== 16'd40) begin
            errors++;
            $display("[TB] FAIL single_grad: %0d/%0d, required 56/40", p8_grad_hs, p8_grad_vs);
        end
        @(negedge clk);
        checks++;
        if (p8_strat !== 1'b0 || p8_res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_wait: strat=%b res_valid=%b, required 0/0", p8_strat, p8_res_valid);
        end
        scaled_hs = 8'd7; scaled_vs = 8'd5; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checks++;
        if (p8_res_valid !== 1'b1 || p8_res_hs !== 8'd7 || p8_res_vs !== 8'd5) begin
            errors++;
            $display("[TB] FAIL single_result: valid=%b res=%0d/%0d, required 1 7/5",
                     p8_res_valid, p8_res_hs, p8_res_vs);
        end
        scaled_hs = 8'd99; scaled_vs = 8'd98;
        @(negedge clk);
        checks++;
        if (p8_res_valid !== 1'b0 || p8_pix_ready !== 1'b1 || p8_res_hs !== 8'd7 || p8_res_vs !== 8'd5) begin
            errors++;
            $display("[TB] FAIL single_after: valid=%b pix_ready=%b res=%0d/%0d, required 0 1 7/5",
                     p8_res_valid, p8_pix_ready, p8_res_hs, p8_res_vs);
        end
    endtask

    task automatic test_gaps_backpressure();
        apply_reset();
        h_a = 8'd4; h_b = 8'd1; v_a = 8'd1; v_b = 8'd9;
        for (int i = 0; i < 15; i++) begin
            pix_valid = (i % 2 == 0);
            @(negedge clk);
            if (i == 13) begin
                checks++;
                if (p8_strat !== 1'b0 || p8_pix_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL gaps_seven: strat=%b pix_ready=%b, required 0/1", p8_strat, p8_pix_ready);
                end
            end
        end
        checks++;
        if (p8_strat !== 1'b1 || p8_grad_hs !== 16'd24 || p8_grad_vs !== 16'd64) begin
            errors++;
            $display("[TB] FAIL gaps_launch: strat=%b grad=%0d/%0d, required 1 24/64",
                     p8_strat, p8_grad_hs, p8_grad_vs);
        end
        // A beat offered from LAUNCH through DONE must stay unconsumed
        h_a = 8'd100; h_b = 8'd0; v_a = 8'd0; v_b = 8'd50;
        pix_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (p8_pix_ready !== 1'b0 || p8_grad_hs !== 16'd24 || p8_grad_vs !== 16'd64) begin
                errors++;
                $display("[TB] FAIL bp_wait: pix_ready=%b grad=%0d/%0d, required 0 24/64",
                         p8_pix_ready, p8_grad_hs, p8_grad_vs);
            end
        end
        ready = 1'b1; scaled_hs = 8'd3; scaled_vs = 8'd8;
        @(negedge clk);
        ready = 1'b0;
        checks++;
        if (p8_res_valid !== 1'b1 || p8_pix_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_done: res_valid=%b pix_ready=%b, required 1/0", p8_res_valid, p8_pix_ready);
        end
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        // The stray beat was withdrawn; a fresh window must count exactly 8 beats
        drive_beats(7, 8'd2, 8'd1, 8'd0, 8'd0);
        checks++;
        if (p8_strat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_count: strat=%b after 7 beats, required 0", p8_strat);
        end
        drive_beats(1, 8'd2, 8'd1, 8'd0, 8'd0);
        checks++;
        if (p8_strat !== 1'b1 || p8_grad_hs !== 16'd8 || p8_grad_vs !== 16'd0) begin
            errors++;
            $display("[TB] FAIL bp_next: strat=%b grad=%0d/%0d, required 1 8/0",
                     p8_strat, p8_grad_hs, p8_grad_vs);
        end
    endtask

    task automatic test_max_magnitude();
        apply_reset();
        drive_beats(254, 8'd255, 8'd0, 8'd0, 8'd0);
        checks++;
        if (pm_strat !== 1'b0 || pm_pix_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL max_early: strat=%b pix_ready=%b, required 0/1", pm_strat, pm_pix_ready);
        end
        drive_beats(1, 8'd255, 8'd0, 8'd0, 8'd0);
        checks++;
        if (pm_strat !== 1'b1 || pm_grad_hs !== 16'd65025 || pm_grad_vs !== 16'd0) begin
            errors++;
            $display("[TB] FAIL max_grad: strat=%b grad=%0d/%0d, required 1 65025/0",
                     pm_strat, pm_grad_hs, pm_grad_vs);
        end
        @(negedge clk);
        ready = 1'b1; scaled_hs = 8'd255; scaled_vs = 8'd1;
        @(negedge clk);
        ready = 1'b0;
        checks++;
        if (pm_res_valid !== 1'b1 || pm_res_hs !== 8'd255 || pm_res_vs !== 8'd1) begin
            errors++;
            $display("[TB] FAIL max_result: valid=%b res=%0d/%0d, required 1 255/1",
                     pm_res_valid, pm_res_hs, pm_res_vs);
        end
    endtask

    task automatic test_ready_handling();
        int strobes;
        apply_reset();
        ready = 1'b1; scaled_hs = 8'd33; scaled_vs = 8'd44;
        drive_beats(8, 8'd1, 8'd0, 8'd0, 8'd2);
        strobes = 0;
        checks++;
        if (p8_strat !== 1'b1 || p8_res_valid !== 1'b0 || p8_grad_hs !== 16'd8 || p8_grad_vs !== 16'd16) begin
            errors++;
            $display("[TB] FAIL stuck_launch: strat=%b valid=%b grad=%0d/%0d, required 1 0 8/16",
                     p8_strat, p8_res_valid, p8_grad_hs, p8_grad_vs);
        end
        @(negedge clk);
        checks++;
        if (p8_res_valid !== 1'b0 || p8_res_hs !== 8'd0) begin
            errors++;
            $display("[TB] FAIL stuck_wait: valid=%b res_hs=%0d, required 0 0", p8_res_valid, p8_res_hs);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (p8_res_valid === 1'b1) strobes++;
        end
        ready = 1'b0;
        checks++;
        if (strobes != 1 || p8_res_hs !== 8'd33 || p8_res_vs !== 8'd44) begin
            errors++;
            $display("[TB] FAIL stuck_once: strobes=%0d res=%0d/%0d, required 1 33/44",
                     strobes, p8_res_hs, p8_res_vs);
        end

        apply_reset();
        drive_beats(8, 8'd5, 8'd0, 8'd3, 8'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (p8_grad_hs !== 16'd40 || p8_grad_vs !== 16'd24 || p8_res_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL delay_hold[%0d]: grad=%0d/%0d valid=%b, required 40/24 0",
                         i, p8_grad_hs, p8_grad_vs, p8_res_valid);
            end
        end
        ready = 1'b1; scaled_hs = 8'd9; scaled_vs = 8'd8;
        @(negedge clk);
        ready = 1'b0;
        checks++;
        if (p8_res_valid !== 1'b1 || p8_res_hs !== 8'd9 || p8_res_vs !== 8'd8) begin
            errors++;
            $display("[TB] FAIL delay_result: valid=%b res=%0d/%0d, required 1 9/8",
                     p8_res_valid, p8_res_hs, p8_res_vs);
        end
    endtask

    task automatic test_reset_mid_wait();
        drive_beats(8, 8'd9, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (p8_pix_ready !== 1'b1 || p8_strat !== 1'b0 || p8_res_valid !== 1'b0 ||
            p8_grad_hs !== 16'd0 || p8_grad_vs !== 16'd0 || p8_res_hs !== 8'd0 || p8_res_vs !== 8'd0) begin
            errors++;
            $display("[TB] FAIL rst_async: rdy=%b strat=%b valid=%b grad=%0d/%0d res=%0d/%0d, required 1 0 0 0/0 0/0",
                     p8_pix_ready, p8_strat, p8_res_valid, p8_grad_hs, p8_grad_vs, p8_res_hs, p8_res_vs);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_beats(8, 8'd3, 8'd1, 8'd2, 8'd3);
        checks++;
        if (p8_strat !== 1'b1 || p8_grad_hs !== 16'd16 || p8_grad_vs !== 16'd8) begin
            errors++;
            $display("[TB] FAIL rst_next: strat=%b grad=%0d/%0d, required 1 16/8",
                     p8_strat, p8_grad_hs, p8_grad_vs);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drive_beats(1, 8'd200, 8'd100, 8'd0, 8'd0);
        checks++;
        if (p1_strat !== 1'b1 || p1_grad_hs !== 16'd100 || p1_grad_vs !== 16'd0) begin
            errors++;
            $display("[TB] FAIL b2b_first: strat=%b grad=%0d/%0d, required 1 100/0",
                     p1_strat, p1_grad_hs, p1_grad_vs);
        end
        h_a = 8'd0; h_b = 8'd1; pix_valid = 1'b1;
        ready = 1'b1; scaled_hs = 8'd50; scaled_vs = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (p1_res_valid !== 1'b1 || p1_res_hs !== 8'd50) begin
            errors++;
            $display("[TB] FAIL b2b_result: valid=%b res_hs=%0d, required 1 50", p1_res_valid, p1_res_hs);
        end
        @(negedge clk);
        checks++;
        if (p1_strat !== 1'b0 || p1_pix_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_accum: strat=%b pix_ready=%b, required 0/1", p1_strat, p1_pix_ready);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        ready = 1'b0;
        checks++;
        if (p1_strat !== 1'b1 || p1_grad_hs !== 16'd1 || p1_grad_vs !== 16'd0) begin
            errors++;
            $display("[TB] FAIL b2b_second: strat=%b grad=%0d/%0d, required 1 1/0",
                     p1_strat, p1_grad_hs, p1_grad_vs);
        end
    endtask

    initial begin
        rst = 1'b1;
        pix_valid = 1'b0;
        ready = 1'b0;
        test_reset();
        test_single_window();
        test_gaps_backpressure();
        test_max_magnitude();
        test_ready_handling();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
